// File: rtl/row_select_seq.sv
// row_select_seq: sequenced row-select driver for the memory array.
//
// Accepts one row-access request at a time over a valid/ready handshake and
// runs a precharge -> wordline-assert -> recovery sequence. Every output except
// req_ready is registered. Requests whose address is >= ROWS are rejected with
// a one-cycle err pulse and never touch the wordlines.
//
// Optional feature (compile-time macro ROW_HIT_EN): remember the last completed
// row; an in-range request to that same row skips the precharge phase.
//
// Ports:
//   clk        clock, all logic on the rising edge
//   rst        synchronous, active-high reset
//   req_valid  request present
//   req_ready  block can accept a request (state IDLE and not in reset)
//   req_addr   row address
//   req_we     1 = write access, 0 = read access
//   sel        one-hot wordline select, all-zero when no wordline is driven
//   precharge  bitline precharge enable
//   we_out     write enable to column drivers, meaningful only while sel != 0
//   busy       high in any state other than IDLE
//   done       one-cycle pulse at the end of a completed access
//   err        one-cycle pulse for a rejected (out-of-range) request
module row_select_seq #(
    parameter int unsigned ADDR_W    = 3,
    parameter int unsigned ROWS      = 8,
    parameter int unsigned PRE_CYC   = 1,
    parameter int unsigned PULSE_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_we,
    output logic [ROWS-1:0]   sel,
    output logic              precharge,
    output logic              we_out,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned MaxCyc = (PRE_CYC > PULSE_CYC) ? PRE_CYC : PULSE_CYC;
    localparam int unsigned CntW   = $clog2(MaxCyc + 1);

    // Counter holds "cycles remaining after this one" in the current phase.
    localparam logic [CntW-1:0] PreLoad   = CntW'(PRE_CYC - 1);
    localparam logic [CntW-1:0] PulseLoad = CntW'(PULSE_CYC - 1);

    // ROWS fits in ADDR_W+1 bits because ROWS <= 2**ADDR_W.
    localparam logic [ADDR_W:0] RowsLim = (ADDR_W + 1)'(ROWS);

    typedef enum logic [1:0] {
        StIdle,
        StPrech,
        StAssert,
        StRecov
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;

    logic [ROWS-1:0]   sel_q, sel_d;
    logic              precharge_q, precharge_d;
    logic              we_out_q, we_out_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              accept;
    logic              in_range;
    logic              row_hit;

    assign req_ready = (state_q == StIdle) & ~rst;
    assign accept    = req_valid & req_ready;
    assign in_range  = ({1'b0, req_addr} < RowsLim);

`ifdef ROW_HIT_EN
    logic [ADDR_W-1:0] last_row_q, last_row_d;
    logic              last_valid_q, last_valid_d;

    assign row_hit = last_valid_q & (req_addr == last_row_q);

    always_comb begin
        last_row_d   = last_row_q;
        last_valid_d = last_valid_q;
        if (err_d) begin
            last_valid_d = 1'b0;
        end else if (state_q == StRecov) begin
            // RECOV is the cycle done is high; the row is valid from the next one.
            last_valid_d = 1'b1;
            last_row_d   = addr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_row_q   <= '0;
            last_valid_q <= 1'b0;
        end else begin
            last_row_q   <= last_row_d;
            last_valid_q <= last_valid_d;
        end
    end
`else
    assign row_hit = 1'b0;
`endif

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        we_d        = we_q;
        err_d       = 1'b0;
        sel_d       = '0;
        precharge_d = 1'b0;
        we_out_d    = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    addr_d = req_addr;
                    we_d   = req_we;
                    if (!in_range) begin
                        err_d = 1'b1;
                    end else if (row_hit) begin
                        state_d = StAssert;
                        cnt_d   = PulseLoad;
                    end else begin
                        state_d = StPrech;
                        cnt_d   = PreLoad;
                    end
                end
            end
            StPrech: begin
                if (cnt_q == '0) begin
                    state_d = StAssert;
                    cnt_d   = PulseLoad;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StAssert: begin
                if (cnt_q == '0) begin
                    state_d = StRecov;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StRecov: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Outputs are registered from the next state so they line up with it.
        precharge_d = (state_d == StPrech);
        busy_d      = (state_d != StIdle);
        done_d      = (state_d == StRecov);
        if (state_d == StAssert) begin
            we_out_d = we_d;
            for (int i = 0; i < int'(ROWS); i++) begin
                sel_d[i] = (addr_d == ADDR_W'(i));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            precharge_q <= 1'b0;
            we_out_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            precharge_q <= precharge_d;
            we_out_q    <= we_out_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign sel       = sel_q;
    assign precharge = precharge_q;
    assign we_out    = we_out_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: doc/row_select_seq.md
Name: row_select_seq

Overview:
Parametrised, sequenced successor to the combinational row-address decoder in the memory array.
- Accepts one row-access request at a time over a valid/ready handshake.
- Runs a precharge → wordline-assert → recovery sequence, driving a registered one-hot row select with programmable phase lengths.
- Sits between the array controller and the wordline drivers; out-of-range addresses are rejected with an error pulse.

Parameters:
ADDR_W, 3, request address width
ROWS, 8, number of physical rows (width of sel); ROWS <= 2**ADDR_W, need not be a power of 2
PRE_CYC, 1, precharge phase length in cycles (>= 1)
PULSE_CYC, 2, wordline-assert phase length in cycles (>= 1)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  block can accept a request
req_addr  input  ADDR_W  row address
req_we  input  1  1 = write access, 0 = read access
sel  output  ROWS  one-hot wordline select; all-zero when idle
precharge  output  1  bitline precharge enable
we_out  output  1  write enable to column drivers; valid only while sel is nonzero
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse at end of a completed access
err  output  1  one-cycle pulse for a rejected (addr >= ROWS) request

Behaviour:
- Reset: state IDLE. sel=0, precharge=0, we_out=0, busy=0, done=0, err=0. Latched addr, latched we and phase counter all 0.
- Reset dominates everything, including mid-sequence: sel and precharge drop at the reset edge, and any in-flight access is abandoned without a done pulse.
- req_ready = (state==IDLE) & ~rst. This is a combinational function of the state register only, never of req_valid.
- Accept: req_valid & req_ready at edge k latches req_addr and req_we.
  - If addr >= ROWS: err=1 in cycle k+1, state stays IDLE, req_ready stays 1, sel never asserts.
  - Otherwise: next state is PRECH.
- FSM states: IDLE, PRECH, ASSERT, RECOV. All outputs are registered.
  - PRECH: precharge=1, sel=0, lasts exactly PRE_CYC cycles (k+1 .. k+PRE_CYC).
  - ASSERT: precharge=0, sel = 1 << latched addr, we_out = latched we, lasts exactly PULSE_CYC cycles.
  - RECOV: sel=0, we_out=0, done=1, lasts 1 cycle, then IDLE.
- Total occupancy per access: PRE_CYC + PULSE_CYC + 1 cycles. A new request can be accepted in the first IDLE cycle after RECOV.
- Phase counter: counts down and reloads on each phase entry. Width is clog2(max(PRE_CYC, PULSE_CYC) + 1).
- Invariants:
  - sel is always zero or one-hot.
  - precharge and sel are never both nonzero in the same cycle.
  - done and err are never high in the same cycle.
- Input handling: req_valid while busy is ignored, with no queueing. req_addr and req_we are sampled only at the accept edge; later changes have no effect.

Optional Feature:
ROW_HIT_EN
- Defined:
  - The block keeps last_row and a last_valid flag. last_valid is set on done and cleared by rst or by err.
  - An accepted, in-range request with addr == last_row and last_valid=1 skips PRECH and goes straight to ASSERT, so sel asserts in cycle k+1.
  - Occupancy for such a hit is PULSE_CYC + 1 cycles.
- Undefined: every access goes through PRECH. last_row and last_valid are not built.

Test Plan:
- Reset, then request addr=5, we=0 (defaults) → precharge=1 in cycle k+1; sel=8'b0010_0000, we_out=0 in k+2..k+3; done=1 in k+4; req_ready=1 in k+5.
- Write to addr=0 with PRE_CYC=2, PULSE_CYC=3 → precharge in k+1..k+2; sel=8'b0000_0001, we_out=1 in k+3..k+5; done in k+6.
- ROWS=6, ADDR_W=3, request addr=7 → err=1 in k+1, sel stays 0, no precharge, req_ready remains 1. Then addr=5 → normal access with sel=6'b100000.
- Hold req_valid high with addr changing every cycle through a full access → only the first address is used, a second accept occurs in the first IDLE cycle, sel stays one-hot throughout.
- Assert rst in the first ASSERT cycle of an addr=3 access → sel=0 and precharge=0 from the next edge, no done pulse, req_ready=1 after rst falls.
- With ROW_HIT_EN defined: two back-to-back reads of addr=2 → the second access has no precharge, sel=8'b0000_0100 in k+1..k+2, done in k+3. A following read of addr=4 does precharge normally.
